// File: rtl/pipe_trace_buffer_pkg.sv
// Shared pipeReg field layout, trace entry format and FSM encodings
// for the pipeline trace buffer.
package pipe_trace_buffer_pkg;

  localparam int PR_PC_LSB    = 0;
  localparam int PR_INSTR_LSB = 32;
  localparam int PR_ALU1_LSB  = 96;
  localparam int PR_RD_LSB    = 160;
  localparam int PR_RWE_BIT   = 165;

  localparam int ENTRY_W = 136;

  typedef enum logic [1:0] {
    TB_IDLE  = 2'd0,
    TB_ARMED = 2'd1,
    TB_POST  = 2'd2,
    TB_DONE  = 2'd3
  } tb_state_e;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu1;
    logic [4:0]  rd;
    logic        rwe;
    logic [1:0]  pad;
  } trace_entry_t;

  // Two pad bits round the entry to 136 bits.
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [31:0] cyc,
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic [31:0] alu1,
    input logic [4:0]  rd,
    input logic        rwe
  );
    trace_entry_t e;
    e.cyc   = cyc;
    e.pc    = pc;
    e.instr = instr;
    e.alu1  = alu1;
    e.rd    = rd;
    e.rwe   = rwe;
    e.pad   = 2'b00;
    return e;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port.
// No reset so it maps onto block RAM.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 136
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Pipeline trace buffer: captures one snooped pipeReg channel around a
// trigger into a circular RAM and drains it oldest-first.
import pipe_trace_buffer_pkg::*;

module pipe_trace_buffer #(
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 32,
  parameter int PIPE_W    = 512,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CH*PIPE_W-1:0] i_pipeReg,
  input  logic [NUM_CH-1:0]        i_pipe_valid,
  input  logic [31:0]              i_cycle,
  input  logic                     i_arm,
  input  logic                     i_abort,
  input  logic [CW-1:0]            i_ch_sel,
  input  logic [31:0]              i_trig_pc,
  input  logic                     i_trig_ext,
  output logic [1:0]               o_state,
  output logic                     o_rd_valid,
  output logic [ENTRY_W-1:0]       o_rd_data,
  input  logic                     i_rd_ready,
  output logic [AW:0]              o_count,
  output logic [AW-1:0]            o_trig_idx
);

  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] PINIT = (AW+1)'(POST_TRIG-1);

  tb_state_e     state, state_n;
  logic [AW-1:0] wptr, wptr_n;
  logic [AW:0]   fill, fill_n;
  logic [AW:0]   post, post_n;
  logic [CW-1:0] sel, sel_n;
  logic [31:0]   tpc, tpc_n;
  logic [AW-1:0] tslot, tslot_n;
  logic [AW:0]   rd_idx, rd_idx_n;
  logic          primed, primed_n;

  logic [PIPE_W-1:0]  bus_sel;
  logic [31:0]        pc_f;
  logic               samp;
  logic               hit;
  logic               we;
  logic               xfer;
  logic               rd_valid;
  logic [AW:0]        rd_inc;
  logic [AW-1:0]      oldest;
  logic [AW-1:0]      rd_addr;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] ram_q;
  logic               unused_bus;

  assign bus_sel    = i_pipeReg[int'(sel)*PIPE_W +: PIPE_W];
  assign unused_bus = ^bus_sel;
  assign pc_f       = bus_sel[PR_PC_LSB +: 32];

  assign wdata = pack_entry(
    i_cycle,
    pc_f,
    bus_sel[PR_INSTR_LSB +: 32],
    bus_sel[PR_ALU1_LSB +: 32],
    bus_sel[PR_RD_LSB +: 5],
    bus_sel[PR_RWE_BIT]
  );

  assign samp = ((state == TB_ARMED) || (state == TB_POST))
              && i_pipe_valid[sel];
  assign hit  = (state == TB_ARMED) && samp
              && ((pc_f == tpc) || i_trig_ext);
  assign we   = samp && !i_abort;

  // fill == DEPTH has zero low bits, so oldest falls back to wptr.
  assign oldest     = wptr - fill[AW-1:0];
  assign o_trig_idx = tslot - oldest;
  assign o_count    = fill;
  assign o_state    = state;

  assign rd_valid   = (state == TB_DONE) && primed && (rd_idx != fill);
  assign xfer       = rd_valid && i_rd_ready;
  assign rd_inc     = rd_idx + 1'b1;
  assign rd_addr    = oldest + rd_idx_n[AW-1:0];
  assign o_rd_valid = rd_valid;
  assign o_rd_data  = rd_valid ? ram_q : '0;

  always_comb begin
    state_n  = state;
    wptr_n   = wptr;
    fill_n   = fill;
    post_n   = post;
    sel_n    = sel;
    tpc_n    = tpc;
    tslot_n  = tslot;
    rd_idx_n = rd_idx;
    primed_n = primed;
    if (samp) begin
      wptr_n = wptr + 1'b1;
      fill_n = (fill == FULL) ? fill : fill + 1'b1;
    end
    unique case (state)
      TB_IDLE: begin
        if (i_arm) begin
          state_n  = TB_ARMED;
          sel_n    = i_ch_sel;
          tpc_n    = i_trig_pc;
          wptr_n   = '0;
          fill_n   = '0;
          rd_idx_n = '0;
          primed_n = 1'b0;
        end
      end
      TB_ARMED: begin
        if (hit) begin
          tslot_n = wptr;
          post_n  = PINIT;
          state_n = (POST_TRIG == 1) ? TB_DONE : TB_POST;
        end
      end
      TB_POST: begin
        if (samp) begin
          post_n = post - 1'b1;
          if (post == (AW+1)'(1)) state_n = TB_DONE;
        end
      end
      TB_DONE: begin
        primed_n = 1'b1;
        if (fill == '0) begin
          state_n = TB_IDLE;
        end else if (xfer) begin
          rd_idx_n = rd_inc;
          if (rd_inc == fill) state_n = TB_IDLE;
        end
      end
      default: state_n = TB_IDLE;
    endcase
    if (i_abort) begin
      state_n  = TB_IDLE;
      wptr_n   = '0;
      fill_n   = '0;
      post_n   = '0;
      tslot_n  = '0;
      rd_idx_n = '0;
      primed_n = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= TB_IDLE;
      wptr   <= '0;
      fill   <= '0;
      post   <= '0;
      sel    <= '0;
      tpc    <= '0;
      tslot  <= '0;
      rd_idx <= '0;
      primed <= 1'b0;
    end else begin
      state  <= state_n;
      wptr   <= wptr_n;
      fill   <= fill_n;
      post   <= post_n;
      sel    <= sel_n;
      tpc    <= tpc_n;
      tslot  <= tslot_n;
      rd_idx <= rd_idx_n;
      primed <= primed_n;
    end
  end

  trace_ram #(
    .DEPTH(DEPTH),
    .W    (ENTRY_W)
  ) u_ram (
    .clk  (i_clk),
    .we   (we),
    .waddr(wptr),
    .wdata(wdata),
    .raddr(rd_addr),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: trigger placement, bubbles,
// back-pressured drain, abort and asynchronous reset.
import pipe_trace_buffer_pkg::*;

module tb_pipe_trace_buffer;

  localparam int NCH = 4;
  localparam int DEP = 8;
  localparam int PT  = 4;
  localparam int PW  = 512;
  localparam int EW  = 136;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*PW-1:0] bus = '0;
  logic [NCH-1:0]    pv = '0;
  logic [31:0]       cyc = 32'd100;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic [1:0]        ch_sel = '0;
  logic [31:0]       trig_pc = '0;
  logic              trig_ext = 1'b0;
  logic [1:0]        st;
  logic              rd_valid;
  logic [EW-1:0]     rd_data;
  logic              rd_ready = 1'b0;
  logic [3:0]        cnt;
  logic [2:0]        tidx;

  int n_chk = 0;
  int n_pass = 0;
  int cur_sel = 0;
  logic [31:0] cyc_at [logic [31:0]];

  always #5 clk = ~clk;

  pipe_trace_buffer #(
    .NUM_CH(NCH), .DEPTH(DEP), .POST_TRIG(PT), .PIPE_W(PW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pipeReg(bus),
    .i_pipe_valid(pv), .i_cycle(cyc), .i_arm(arm),
    .i_abort(abort), .i_ch_sel(ch_sel), .i_trig_pc(trig_pc),
    .i_trig_ext(trig_ext), .o_state(st), .o_rd_valid(rd_valid),
    .o_rd_data(rd_data), .i_rd_ready(rd_ready), .o_count(cnt),
    .o_trig_idx(tidx)
  );

  task automatic chk(input string tag, input logic [EW-1:0] got,
                     input logic [EW-1:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  function automatic logic [EW-1:0] exp_entry(input logic [31:0] pc);
    logic [31:0] c;
    c = cyc_at.exists(pc) ? cyc_at[pc] : 32'hxxxx_xxxx;
    return {c, pc, pc ^ 32'hA5A5_0000, pc + 32'd1, pc[6:2], pc[3], 2'b00};
  endfunction

  task automatic set_ch(input int c, input logic [31:0] pc);
    bus[c*PW + PR_PC_LSB +: 32]    = pc;
    bus[c*PW + PR_INSTR_LSB +: 32] = pc ^ 32'hA5A5_0000;
    bus[c*PW + PR_ALU1_LSB +: 32]  = pc + 32'd1;
    bus[c*PW + PR_RD_LSB +: 5]     = pc[6:2];
    bus[c*PW + PR_RWE_BIT]         = pc[3];
  endtask

  // Other channels carry the trigger PC so a wrong mux fires early.
  task automatic feed(input logic [31:0] pc, input logic v,
                      input logic ext = 1'b0, input logic ab = 1'b0);
    for (int c = 0; c < NCH; c++) begin
      if (c == cur_sel) begin
        set_ch(c, pc);
        pv[c] = v;
      end else begin
        set_ch(c, trig_pc);
        pv[c] = 1'b1;
      end
    end
    trig_ext = ext;
    abort = ab;
    if (v) cyc_at[pc] = cyc;
    tick();
    trig_ext = 1'b0;
    abort = 1'b0;
    pv = '0;
  endtask

  task automatic do_arm(input int ch, input logic [31:0] tpc);
    ch_sel = 2'(ch);
    trig_pc = tpc;
    cur_sel = ch;
    pv = '0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("armed", EW'(st), EW'(1));
  endtask

  task automatic drain(input logic [31:0] pc0, input int n,
                       input bit rnd);
    int k = 0;
    int budget = 0;
    logic r;
    while (k < n && budget < 300) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_ready = r;
      if (rd_valid) begin
        chk("rd_data", rd_data, exp_entry(pc0 + 32'(4 * k)));
        if (r) k++;
      end
      tick();
      budget++;
    end
    rd_ready = 1'b0;
    chk("xfers", EW'(k), EW'(n));
    chk("idle_after", EW'(st), EW'(0));
    chk("valid_after", EW'(rd_valid), EW'(0));
  endtask

  initial begin
    #2;
    chk("rst_state", EW'(st), EW'(0));
    chk("rst_valid", EW'(rd_valid), EW'(0));
    chk("rst_count", EW'(cnt), EW'(0));
    chk("rst_tidx", EW'(tidx), EW'(0));
    chk("rst_data", rd_data, EW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // wrap with history overwrite, trigger mid-stream
    do_arm(1, 32'h120);
    for (int n = 0; n < 20; n++) begin
      feed(32'h100 + 32'(4 * n), 1'b1);
      if (n == 7) chk("t1_armed", EW'(st), EW'(1));
      if (n == 8) chk("t1_post", EW'(st), EW'(2));
      if (n == 10) chk("t1_post2", EW'(st), EW'(2));
      if (n == 11) chk("t1_done", EW'(st), EW'(3));
    end
    chk("t1_count", EW'(cnt), EW'(8));
    chk("t1_tidx", EW'(tidx), EW'(4));
    drain(32'h110, 8, 1'b0);

    // early trigger, partial fill
    do_arm(1, 32'h104);
    for (int n = 0; n < 7; n++) begin
      feed(32'h100 + 32'(4 * n), 1'b1);
      if (n == 3) chk("t2_post", EW'(st), EW'(2));
      if (n == 4) chk("t2_done", EW'(st), EW'(3));
    end
    chk("t2_count", EW'(cnt), EW'(5));
    chk("t2_tidx", EW'(tidx), EW'(1));
    drain(32'h100, 5, 1'b0);

    // external trigger, bubbles during POST
    do_arm(2, 32'h1234_5678);
    feed(32'h200, 1'b1);
    feed(32'h204, 1'b1);
    feed(32'h208, 1'b1, 1'b1);
    chk("t3_post", EW'(st), EW'(2));
    feed(32'hBAD0, 1'b0);
    feed(32'h20C, 1'b1);
    feed(32'hBAD4, 1'b0, 1'b1);
    feed(32'h210, 1'b1);
    feed(32'hBAD8, 1'b0);
    chk("t3_post2", EW'(st), EW'(2));
    feed(32'h214, 1'b1);
    chk("t3_done", EW'(st), EW'(3));
    chk("t3_count", EW'(cnt), EW'(6));
    chk("t3_tidx", EW'(tidx), EW'(2));
    drain(32'h200, 6, 1'b0);

    // random back-pressure on drain
    do_arm(3, 32'h418);
    for (int n = 0; n < 10; n++) begin
      feed(32'h400 + 32'(4 * n), 1'b1);
      if (n == 6) chk("t4_post", EW'(st), EW'(2));
    end
    chk("t4_done", EW'(st), EW'(3));
    chk("t4_count", EW'(cnt), EW'(8));
    chk("t4_tidx", EW'(tidx), EW'(4));
    drain(32'h408, 8, 1'b1);

    // abort in POST, then abort mid-readout
    do_arm(1, 32'h508);
    feed(32'h500, 1'b1);
    feed(32'h504, 1'b1);
    feed(32'h508, 1'b1);
    chk("t5_post", EW'(st), EW'(2));
    feed(32'h50C, 1'b1, 1'b0, 1'b1);
    chk("t5_abort_st", EW'(st), EW'(0));
    chk("t5_abort_v", EW'(rd_valid), EW'(0));
    do_arm(1, 32'h604);
    for (int n = 0; n < 5; n++) feed(32'h600 + 32'(4 * n), 1'b1);
    chk("t5_done", EW'(st), EW'(3));
    chk("t5_count", EW'(cnt), EW'(5));
    chk("t5_tidx", EW'(tidx), EW'(1));
    chk("t5_bubble", EW'(rd_valid), EW'(0));
    tick();
    chk("t5_v0", EW'(rd_valid), EW'(1));
    chk("t5_d0", rd_data, exp_entry(32'h600));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("t5_v1", EW'(rd_valid), EW'(1));
    chk("t5_d1", rd_data, exp_entry(32'h604));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_rabort_st", EW'(st), EW'(0));
    chk("t5_rabort_v", EW'(rd_valid), EW'(0));
    do_arm(0, 32'h700);
    for (int n = 0; n < 4; n++) feed(32'h700 + 32'(4 * n), 1'b1);
    chk("t5b_done", EW'(st), EW'(3));
    chk("t5b_count", EW'(cnt), EW'(4));
    chk("t5b_tidx", EW'(tidx), EW'(0));
    drain(32'h700, 4, 1'b0);

    // asynchronous reset while ARMED
    do_arm(2, 32'h800);
    feed(32'h900, 1'b1);
    feed(32'h904, 1'b1);
    feed(32'h908, 1'b1);
    chk("t6_armed", EW'(st), EW'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_st", EW'(st), EW'(0));
    chk("t6_rst_v", EW'(rd_valid), EW'(0));
    chk("t6_rst_cnt", EW'(cnt), EW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_arm(2, 32'h904);
    for (int n = 0; n < 5; n++) feed(32'h900 + 32'(4 * n), 1'b1);
    chk("t6_done", EW'(st), EW'(3));
    chk("t6_count", EW'(cnt), EW'(5));
    chk("t6_tidx", EW'(tidx), EW'(1));
    drain(32'h900, 5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
